id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage MIPS core: registers decoded operands, register specifiers and control bits from ID into EX, and owns the load-use hazard check. It feeds the EX-stage forwarding unit, which consumes `ID_Ex_Rs` and `ID_Ex_Rt`. On a load-use hazard it freezes PC and IF/ID and inserts one bubble. On an EX-resolved branch or jump flush it squashes the ID/EX contents. It also keeps a saturating stall-cycle counter for performance reporting.

---
 rtl/id_ex_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with the load-use hazard check and a saturating stall counter.
// Latency: every ID_Ex_* output follows its ID input by 1 cycle; Stall/PCWrite/IF_IdWrite are combinational.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and loads a bubble; a flush overrides it.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        IF_Id_Rs,
    input  logic [4:0]        IF_Id_Rt,
    input  logic              IF_Id_UsesRt,
    input  logic [4:0]        Id_Rd,
    input  logic [DATA_W-1:0] Id_ReadData1,
    input  logic [DATA_W-1:0] Id_ReadData2,
    input  logic [DATA_W-1:0] Id_SignExt,
    input  logic              Id_Valid,
    input  logic              Id_RegWrite,
    input  logic              Id_MemtoReg,
    input  logic              Id_MemRead,
    input  logic              Id_MemWrite,
    input  logic              Id_ALUSrc,
    input  logic              Id_RegDst,
    input  logic [1:0]        Id_ALUOp,
    input  logic              Ex_Flush,
    output logic [4:0]        ID_Ex_Rs,
    output logic [4:0]        ID_Ex_Rt,
    output logic [4:0]        ID_Ex_Rd,
    output logic [DATA_W-1:0] ID_Ex_ReadData1,
    output logic [DATA_W-1:0] ID_Ex_ReadData2,
    output logic [DATA_W-1:0] ID_Ex_SignExt,
    output logic              ID_Ex_RegWrite,
    output logic              ID_Ex_MemtoReg,
    output logic              ID_Ex_MemRead,
    output logic              ID_Ex_MemWrite,
    output logic              ID_Ex_ALUSrc,
    output logic              ID_Ex_RegDst,
    output logic [1:0]        ID_Ex_ALUOp,
    output logic              ID_Ex_Valid,
    output logic              Stall,
    output logic              PCWrite,
    output logic              IF_IdWrite,
    output logic [CNT_W-1:0]  StallCount
);

    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              memtoReg;
        logic              memRead;
        logic              memWrite;
        logic              aluSrc;
        logic              regDst;
        logic [1:0]        aluOp;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] readData1;
        logic [DATA_W-1:0] readData2;
        logic [DATA_W-1:0] signExt;
    } idExReg_t;

    idExReg_t         exReg;
    idExReg_t         exNext;
    logic             rtMatch;
    logic             loadBubble;
    logic [CNT_W-1:0] stallCnt;

    // Only the load's destination (Rt) is compared; $0 is never a real dependency.
    always_comb begin
        rtMatch = (exReg.rt == IF_Id_Rs) | (IF_Id_UsesRt & (exReg.rt == IF_Id_Rt));
        Stall   = ~Ex_Flush & exReg.valid & exReg.memRead & (exReg.rt != 5'd0) & Id_Valid & rtMatch;
    end

    assign PCWrite    = ~Stall;
    assign IF_IdWrite = ~Stall;
    assign loadBubble = Ex_Flush | Stall | ~Id_Valid;

    // A bubble zeroes the specifiers too so forwarding compares against $0 and never fires.
    always_comb begin
        exNext = '0;
        if (!loadBubble) begin
            exNext.valid     = 1'b1;
            exNext.regWrite  = Id_RegWrite;
            exNext.memtoReg  = Id_MemtoReg;
            exNext.memRead   = Id_MemRead;
            exNext.memWrite  = Id_MemWrite;
            exNext.aluSrc    = Id_ALUSrc;
            exNext.regDst    = Id_RegDst;
            exNext.aluOp     = Id_ALUOp;
            exNext.rs        = IF_Id_Rs;
            exNext.rt        = IF_Id_Rt;
            exNext.rd        = Id_Rd;
            exNext.readData1 = Id_ReadData1;
            exNext.readData2 = Id_ReadData2;
            exNext.signExt   = Id_SignExt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exReg <= '0;
        end else begin
            exReg <= exNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (Stall && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign ID_Ex_Rs        = exReg.rs;
    assign ID_Ex_Rt        = exReg.rt;
    assign ID_Ex_Rd        = exReg.rd;
    assign ID_Ex_ReadData1 = exReg.readData1;
    assign ID_Ex_ReadData2 = exReg.readData2;
    assign ID_Ex_SignExt   = exReg.signExt;
    assign ID_Ex_RegWrite  = exReg.regWrite;
    assign ID_Ex_MemtoReg  = exReg.memtoReg;
    assign ID_Ex_MemRead   = exReg.memRead;
    assign ID_Ex_MemWrite  = exReg.memWrite;
    assign ID_Ex_ALUSrc    = exReg.aluSrc;
    assign ID_Ex_RegDst    = exReg.regDst;
    assign ID_Ex_ALUOp     = exReg.aluOp;
    assign ID_Ex_Valid     = exReg.valid;
    assign StallCount      = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic, checked against an
// instruction-level model of what occupies EX and how many stall cycles have been seen.
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [4:0]    IF_Id_Rs, IF_Id_Rt, Id_Rd;
    logic          IF_Id_UsesRt;
    logic [DW-1:0] Id_ReadData1, Id_ReadData2, Id_SignExt;
    logic          Id_Valid, Id_RegWrite, Id_MemtoReg, Id_MemRead, Id_MemWrite, Id_ALUSrc, Id_RegDst;
    logic [1:0]    Id_ALUOp;
    logic          Ex_Flush;
    logic [4:0]    ID_Ex_Rs, ID_Ex_Rt, ID_Ex_Rd;
    logic [DW-1:0] ID_Ex_ReadData1, ID_Ex_ReadData2, ID_Ex_SignExt;
    logic          ID_Ex_RegWrite, ID_Ex_MemtoReg, ID_Ex_MemRead, ID_Ex_MemWrite, ID_Ex_ALUSrc, ID_Ex_RegDst;
    logic [1:0]    ID_Ex_ALUOp;
    logic          ID_Ex_Valid, Stall, PCWrite, IF_IdWrite;
    logic [CW-1:0] StallCount;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_Id_Rs(IF_Id_Rs), .IF_Id_Rt(IF_Id_Rt), .IF_Id_UsesRt(IF_Id_UsesRt), .Id_Rd(Id_Rd),
        .Id_ReadData1(Id_ReadData1), .Id_ReadData2(Id_ReadData2), .Id_SignExt(Id_SignExt),
        .Id_Valid(Id_Valid), .Id_RegWrite(Id_RegWrite), .Id_MemtoReg(Id_MemtoReg),
        .Id_MemRead(Id_MemRead), .Id_MemWrite(Id_MemWrite), .Id_ALUSrc(Id_ALUSrc),
        .Id_RegDst(Id_RegDst), .Id_ALUOp(Id_ALUOp), .Ex_Flush(Ex_Flush),
        .ID_Ex_Rs(ID_Ex_Rs), .ID_Ex_Rt(ID_Ex_Rt), .ID_Ex_Rd(ID_Ex_Rd),
        .ID_Ex_ReadData1(ID_Ex_ReadData1), .ID_Ex_ReadData2(ID_Ex_ReadData2),
        .ID_Ex_SignExt(ID_Ex_SignExt), .ID_Ex_RegWrite(ID_Ex_RegWrite),
        .ID_Ex_MemtoReg(ID_Ex_MemtoReg), .ID_Ex_MemRead(ID_Ex_MemRead),
        .ID_Ex_MemWrite(ID_Ex_MemWrite), .ID_Ex_ALUSrc(ID_Ex_ALUSrc), .ID_Ex_RegDst(ID_Ex_RegDst),
        .ID_Ex_ALUOp(ID_Ex_ALUOp), .ID_Ex_Valid(ID_Ex_Valid), .Stall(Stall), .PCWrite(PCWrite),
        .IF_IdWrite(IF_IdWrite), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the bench believes it to be.
    typedef struct {
        bit            valid;
        bit [4:0]      rs, rt, rd;
        bit [DW-1:0]   d1, d2, se;
        bit            regWrite, memtoReg, memRead, memWrite, aluSrc, regDst;
        bit [1:0]      aluOp;
    } exInstr_t;

    exInstr_t inEx;
    int       stallCycles;
    bit       modelKnown;
    int       errors;
    int       checks;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dependsOnLoad();
        if (Ex_Flush || !Id_Valid || !inEx.valid || !inEx.memRead || inEx.rt == 5'd0) return 1'b0;
        if (inEx.rt == IF_Id_Rs) return 1'b1;
        return IF_Id_UsesRt && (inEx.rt == IF_Id_Rt);
    endfunction

    // One clock: check the hazard outputs, take the edge, advance the model, check EX contents.
    task automatic step(input string tag, input int wantStall);
        bit expStall;
        #1;
        expStall = dependsOnLoad();
        if (modelKnown) begin
            chk({tag, ".Stall"}, Stall, expStall);
            chk({tag, ".PCWrite"}, PCWrite, !expStall);
            chk({tag, ".IF_IdWrite"}, IF_IdWrite, !expStall);
            if (wantStall >= 0) chk({tag, ".StallDirected"}, Stall, wantStall[0]);
        end
        @(posedge clk);
        if (rst) begin
            inEx = '{default: 0};
            stallCycles = 0;
            modelKnown = 1'b1;
        end else begin
            if (Ex_Flush || expStall || !Id_Valid) begin
                inEx = '{default: 0};
            end else begin
                inEx = '{valid: 1'b1, rs: IF_Id_Rs, rt: IF_Id_Rt, rd: Id_Rd,
                         d1: Id_ReadData1, d2: Id_ReadData2, se: Id_SignExt,
                         regWrite: Id_RegWrite, memtoReg: Id_MemtoReg, memRead: Id_MemRead,
                         memWrite: Id_MemWrite, aluSrc: Id_ALUSrc, regDst: Id_RegDst,
                         aluOp: Id_ALUOp};
            end
            if (expStall && stallCycles < CMAX) stallCycles++;
        end
        #1;
        if (modelKnown) begin
            chk({tag, ".Rs"}, ID_Ex_Rs, inEx.rs);
            chk({tag, ".Rt"}, ID_Ex_Rt, inEx.rt);
            chk({tag, ".Rd"}, ID_Ex_Rd, inEx.rd);
            chk({tag, ".ReadData1"}, ID_Ex_ReadData1, inEx.d1);
            chk({tag, ".ReadData2"}, ID_Ex_ReadData2, inEx.d2);
            chk({tag, ".SignExt"}, ID_Ex_SignExt, inEx.se);
            chk({tag, ".Ctrl"},
                {ID_Ex_RegWrite, ID_Ex_MemtoReg, ID_Ex_MemRead, ID_Ex_MemWrite, ID_Ex_ALUSrc,
                 ID_Ex_RegDst, ID_Ex_ALUOp},
                {inEx.regWrite, inEx.memtoReg, inEx.memRead, inEx.memWrite, inEx.aluSrc,
                 inEx.regDst, inEx.aluOp});
            chk({tag, ".Valid"}, ID_Ex_Valid, inEx.valid);
            chk({tag, ".StallCount"}, StallCount, stallCycles);
        end
        @(negedge clk);
    endtask

    task automatic randomInputs();
        IF_Id_Rs     = 5'($urandom_range(0, 3));
        IF_Id_Rt     = 5'($urandom_range(0, 3));
        IF_Id_UsesRt = 1'($urandom);
        Id_Rd        = 5'($urandom);
        Id_ReadData1 = $urandom;
        Id_ReadData2 = $urandom;
        Id_SignExt   = $urandom;
        Id_Valid     = ($urandom_range(0, 9) != 0);
        Id_RegWrite  = 1'($urandom);
        Id_MemtoReg  = 1'($urandom);
        Id_MemRead   = ($urandom_range(0, 9) < 4);
        Id_MemWrite  = 1'($urandom);
        Id_ALUSrc    = 1'($urandom);
        Id_RegDst    = 1'($urandom);
        Id_ALUOp     = 2'($urandom);
        Ex_Flush     = ($urandom_range(0, 9) == 0);
    endtask

    task automatic instr(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d,
                         input bit usesT, input bit memRd, input bit regWr);
        IF_Id_Rs = s; IF_Id_Rt = t; Id_Rd = d; IF_Id_UsesRt = usesT;
        Id_ReadData1 = $urandom; Id_ReadData2 = $urandom; Id_SignExt = $urandom;
        Id_Valid = 1'b1; Id_RegWrite = regWr; Id_MemtoReg = memRd; Id_MemRead = memRd;
        Id_MemWrite = 1'b0; Id_ALUSrc = memRd; Id_RegDst = !memRd; Id_ALUOp = memRd ? 2'b00 : 2'b10;
        Ex_Flush = 1'b0;
    endtask

    task automatic resetCycles(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            randomInputs();
            step("reset", -1);
        end
        rst = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; modelKnown = 1'b0; stallCycles = 0;
        inEx = '{default: 0};
        rst = 1'b1;
        randomInputs();
        @(negedge clk);

        // Reset with random ID inputs, then confirm the cleared state against constants.
        resetCycles(2);
        #1;
        chk("rst.StallConst", Stall, 1'b0);
        chk("rst.PCWriteConst", PCWrite, 1'b1);
        chk("rst.ValidConst", ID_Ex_Valid, 1'b0);
        chk("rst.CountConst", StallCount, 0);
        @(negedge clk);

        // add $3,$1,$2 passes straight through.
        instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
        Id_ReadData1 = 32'h11; Id_ReadData2 = 32'h22;
        step("add", 0);
        chk("add.RsConst", ID_Ex_Rs, 5'd1);
        chk("add.Data1Const", ID_Ex_ReadData1, 32'h11);
        chk("add.Data2Const", ID_Ex_ReadData2, 32'h22);

        // lw $5 then a consumer of $5 in Rs: one stall cycle, one bubble.
        instr(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        step("lw5", 0);
        instr(5'd5, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1);
        step("useRs", 1);
        chk("useRs.BubbleValid", ID_Ex_Valid, 1'b0);
        chk("useRs.Count", StallCount, 1);
        step("useRsHeld", 0);

        // Match only on Rt while the consumer does not read Rt: no stall.
        instr(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        step("lw5b", 0);
        instr(5'd6, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1);
        step("rtNoUse", 0);

        // Load to $0 with a dependent consumer, and a non-load producing $5.
        instr(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("lw0", 0);
        instr(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
        step("use0", 0);
        instr(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
        step("addi5", 0);
        instr(5'd5, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1);
        step("useNonLoad", 0);

        // Flush coincident with a load-use hazard: flush wins, counter untouched.
        instr(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        step("lw5c", 0);
        instr(5'd5, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1);
        Ex_Flush = 1'b1;
        step("flushHazard", 0);
        chk("flush.Count", StallCount, 1);
        chk("flush.Valid", ID_Ex_Valid, 1'b0);

        // Reset arriving while a stall is pending discards it.
        instr(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        step("lw5d", 0);
        instr(5'd5, 5'd1, 5'd4, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step("rstDuringStall", 1);
        rst = 1'b0;
        chk("rstStall.Count", StallCount, 0);

        // lw $2 ; lw $3,0($2) ; add using $3  -> two stall cycles.
        instr(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1);
        step("b2b.lw2", 0);
        instr(5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
        step("b2b.lw3stall", 1);
        step("b2b.lw3go", 0);
        instr(5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);
        step("b2b.addStall", 1);
        step("b2b.addGo", 0);
        chk("b2b.Count", StallCount, 2);

        // Twenty separate stall events saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            instr(5'd1, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1);
            step("sat.lw", -1);
            instr(5'd2, 5'd6, 5'd4, 1'b1, 1'b0, 1'b1);
            step("sat.use", 1);
            step("sat.go", 0);
        end
        chk("sat.Count", StallCount, 15);
        resetCycles(1);
        chk("sat.CountAfterRst", StallCount, 0);

        // Random traffic with frequent short-range register collisions.
        for (int i = 0; i < 400; i++) begin
            randomInputs();
            rst = ($urandom_range(0, 49) == 0);
            step("rand", -1);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
